// File: rtl/mips_hazard_pkg.sv
// ---------------------------------------------------------------------------
// mips_hazard_pkg
//   Shared definitions for the MIPS pipeline hazard unit:
//   - forwarding select encodings for the execute operand muxes
//   - watchdog state enumeration
//   - the hard-wired zero register number
//   - small helper functions for register-match and forward-select decode
// ---------------------------------------------------------------------------
package mips_hazard_pkg;

  // Register $0 is hard-wired to zero, so it never creates a real dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Execute-stage operand select: take the register file value, the value
  // being written back, or the ALU result sitting in the memory stage.
  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  // Watchdog states: normal running, inside a stall run, and latched hang.
  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    HUNG  = 2'b10
  } wd_state_e;

  // True when a source register is a real (non-zero) match to a writer.
  function automatic logic regMatch(input logic [4:0] src, input logic [4:0] dst);
    return (src != REG_ZERO) && (src == dst);
  endfunction

  // Execute-stage forward decode. The memory stage holds the younger result,
  // so it must win over the writeback stage when both target the same register.
  function automatic fwd_sel_e fwdSelect(
    input logic [4:0] src,
    input logic [4:0] memDst,
    input logic       memWrite,
    input logic [4:0] wbDst,
    input logic       wbWrite
  );
    fwd_sel_e sel;
    sel = FWD_NONE;
    if (memWrite && regMatch(src, memDst)) begin
      sel = FWD_MEM;
    end else if (wbWrite && regMatch(src, wbDst)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_perf_counter.sv
// ---------------------------------------------------------------------------
// hazard_perf_counter
//   Saturating event counter used for stall statistics.
//   Ports:
//     clk    pipeline clock
//     rst    asynchronous active-high reset (count -> 0)
//     inc    count one event on the next rising edge
//     clr    synchronous clear; wins over a same-cycle inc
//     count  current count, sticks at all-ones once reached
// ---------------------------------------------------------------------------
module hazard_perf_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next-count decode: a clear always lands on zero, otherwise an event
  // advances the count unless it has already saturated at all-ones, so a
  // long-running debug session never wraps back to a misleading small value.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register, cleared asynchronously together with the pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
//   Hazard detection and forwarding control for the 5-stage MIPS pipeline.
//   Ports:
//     clk, rst                    clock / asynchronous active-high reset
//     RsD, RtD, BranchD           decode-stage sources and branch flag
//     RsE, RtE                    execute-stage sources
//     WriteRegE/M/W, RegWriteE/M/W destination and write enable per stage
//     MemtoRegE, MemtoRegM        stage holds a load
//     count_clr                   synchronous clear of both stall counters
//     StallF, StallD, FlushE      stall fetch/decode, flush decode/execute
//     ForwardAE, ForwardBE        execute operand forward selects
//     ForwardAD, ForwardBD        decode comparator forward from memory stage
//     lw_stall_count, br_stall_count  saturating stall cycle counters
//     deadlock                    sticky watchdog flag
// ---------------------------------------------------------------------------
module hazard_unit
  import mips_hazard_pkg::*;
#(
  parameter int COUNT_WIDTH    = 32,
  parameter int DEADLOCK_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             RsD,
  input  logic [4:0]             RtD,
  input  logic                   BranchD,
  input  logic [4:0]             RsE,
  input  logic [4:0]             RtE,
  input  logic [4:0]             WriteRegE,
  input  logic [4:0]             WriteRegM,
  input  logic [4:0]             WriteRegW,
  input  logic                   RegWriteE,
  input  logic                   RegWriteM,
  input  logic                   RegWriteW,
  input  logic                   MemtoRegE,
  input  logic                   MemtoRegM,
  input  logic                   count_clr,
  output logic                   StallF,
  output logic                   StallD,
  output logic                   FlushE,
  output logic [1:0]             ForwardAE,
  output logic [1:0]             ForwardBE,
  output logic                   ForwardAD,
  output logic                   ForwardBD,
  output logic [COUNT_WIDTH-1:0] lw_stall_count,
  output logic [COUNT_WIDTH-1:0] br_stall_count,
  output logic                   deadlock
);

  // The watchdog trips on the edge that completes DEADLOCK_LIMIT stalled
  // cycles; run_len already counts the first one on entry to STALL.
  localparam logic [7:0] LIMIT_M1 = 8'(DEADLOCK_LIMIT - 1);

  logic      lwStall;
  logic      brStall;
  logic      stall;
  wd_state_e state_q;
  logic [7:0] runLen_q;
  logic      deadlock_q;

  // Execute-stage forwarding. Both operands use the same priority decode,
  // memory stage first because it carries the most recent result.
  always_comb begin
    ForwardAE = fwdSelect(RsE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
    ForwardBE = fwdSelect(RtE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
  end

  // The branch comparator sits in decode, so only a memory-stage ALU result
  // can be forwarded to it; anything younger has to stall instead.
  always_comb begin
    ForwardAD = RegWriteM && regMatch(RsD, WriteRegM);
    ForwardBD = RegWriteM && regMatch(RtD, WriteRegM);
  end

  // Load-use hazard: the load in execute produces its data only after the
  // memory stage, so a decode instruction reading that register must wait.
  // Branch hazard: a branch compares in decode and needs its operands one
  // stage earlier than an ALU op, so it waits on an ALU write still in
  // execute, and on a load still in memory.
  always_comb begin
    lwStall = MemtoRegE && (RtE != REG_ZERO) && ((RsD == RtE) || (RtD == RtE));
    brStall = BranchD &&
              ((RegWriteE && (WriteRegE != REG_ZERO) &&
                ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
               (MemtoRegM && (WriteRegM != REG_ZERO) &&
                ((WriteRegM == RsD) || (WriteRegM == RtD))));
    stall   = lwStall || brStall;
  end

  // Stall and flush are suppressed during reset so the pipeline registers
  // are not held or bubbled while everything is being initialised.
  always_comb begin
    StallF = stall && !rst;
    StallD = stall && !rst;
    FlushE = stall && !rst;
  end

  // Per-cause stall statistics; both may count in the same cycle when a
  // branch and a load-use dependency coincide.
  hazard_perf_counter #(
    .WIDTH (COUNT_WIDTH)
  ) u_lw_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (lwStall),
    .clr   (count_clr),
    .count (lw_stall_count)
  );

  hazard_perf_counter #(
    .WIDTH (COUNT_WIDTH)
  ) u_br_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (brStall),
    .clr   (count_clr),
    .count (br_stall_count)
  );

  // Deadlock watchdog. A legal lw->branch sequence stalls for two cycles at
  // most, so a run reaching the limit means the pipeline is wedged. HUNG is
  // absorbing until reset so a debugger can still see it after the fact;
  // the stall/forward logic keeps running regardless. The deadlock flag is
  // registered alongside the state so it changes on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      runLen_q   <= 8'd0;
      deadlock_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (stall) begin
            state_q  <= STALL;
            runLen_q <= 8'd1;
          end
        end
        STALL: begin
          if (stall) begin
            if (runLen_q == LIMIT_M1) begin
              state_q    <= HUNG;
              deadlock_q <= 1'b1;
            end else begin
              runLen_q <= runLen_q + 8'd1;
            end
          end else begin
            state_q  <= RUN;
            runLen_q <= 8'd0;
          end
        end
        HUNG: begin
          deadlock_q <= 1'b1;
        end
        default: begin
          state_q    <= RUN;
          runLen_q   <= 8'd0;
          deadlock_q <= 1'b0;
        end
      endcase
    end
  end

  assign deadlock = deadlock_q;

endmodule

// File: tb/tb_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_unit
//   Self-checking bench for hazard_unit with a small COUNT_WIDTH so that
//   counter saturation is reachable. A behavioural model tracks the expected
//   counters and watchdog as plain integers.
// ---------------------------------------------------------------------------
module tb_hazard_unit;

  localparam int CW    = 4;
  localparam int LIMIT = 4;
  localparam int SAT   = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic [4:0]    RsD, RtD, RsE, RtE;
  logic [4:0]    WriteRegE, WriteRegM, WriteRegW;
  logic          BranchD, RegWriteE, RegWriteM, RegWriteW;
  logic          MemtoRegE, MemtoRegM, count_clr;
  logic          StallF, StallD, FlushE;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          ForwardAD, ForwardBD;
  logic [CW-1:0] lw_stall_count, br_stall_count;
  logic          deadlock;

  int checkCount = 0;
  int failCount  = 0;

  // Reference model state: counts as integers, watchdog as a length of the
  // current consecutive stall run plus a sticky hang flag.
  int mLw     = 0;
  int mBr     = 0;
  int mConsec = 0;
  bit mHung   = 0;

  hazard_unit #(
    .COUNT_WIDTH    (CW),
    .DEADLOCK_LIMIT (LIMIT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .RsD            (RsD),
    .RtD            (RtD),
    .BranchD        (BranchD),
    .RsE            (RsE),
    .RtE            (RtE),
    .WriteRegE      (WriteRegE),
    .WriteRegM      (WriteRegM),
    .WriteRegW      (WriteRegW),
    .RegWriteE      (RegWriteE),
    .RegWriteM      (RegWriteM),
    .RegWriteW      (RegWriteW),
    .MemtoRegE      (MemtoRegE),
    .MemtoRegM      (MemtoRegM),
    .count_clr      (count_clr),
    .StallF         (StallF),
    .StallD         (StallD),
    .FlushE         (FlushE),
    .ForwardAE      (ForwardAE),
    .ForwardBE      (ForwardBE),
    .ForwardAD      (ForwardAD),
    .ForwardBD      (ForwardBD),
    .lw_stall_count (lw_stall_count),
    .br_stall_count (br_stall_count),
    .deadlock       (deadlock)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Expected hazard conditions taken directly from the pipeline rules.
  function automatic bit modelLw();
    return MemtoRegE && (RtE != 0) && ((RsD == RtE) || (RtD == RtE));
  endfunction

  function automatic bit modelBr();
    bit eHit, mHit;
    eHit = RegWriteE && (WriteRegE != 0) && ((WriteRegE == RsD) || (WriteRegE == RtD));
    mHit = MemtoRegM && (WriteRegM != 0) && ((WriteRegM == RsD) || (WriteRegM == RtD));
    return BranchD && (eHit || mHit);
  endfunction

  function automatic logic [1:0] expFwd(input logic [4:0] src);
    if (src != 0 && src == WriteRegM && RegWriteM) return 2'b10;
    if (src != 0 && src == WriteRegW && RegWriteW) return 2'b01;
    return 2'b00;
  endfunction

  task automatic checkComb();
    bit s;
    s = (modelLw() || modelBr()) && !rst;
    checkOutput("StallF", 32'(StallF), 32'(s));
    checkOutput("StallD", 32'(StallD), 32'(s));
    checkOutput("FlushE", 32'(FlushE), 32'(s));
    checkOutput("ForwardAE", 32'(ForwardAE), 32'(expFwd(RsE)));
    checkOutput("ForwardBE", 32'(ForwardBE), 32'(expFwd(RtE)));
    checkOutput("ForwardAD", 32'(ForwardAD), 32'(RsD != 0 && RsD == WriteRegM && RegWriteM));
    checkOutput("ForwardBD", 32'(ForwardBD), 32'(RtD != 0 && RtD == WriteRegM && RegWriteM));
  endtask

  task automatic checkRegs();
    checkOutput("lwCount", 32'(lw_stall_count), 32'(mLw));
    checkOutput("brCount", 32'(br_stall_count), 32'(mBr));
    checkOutput("deadlock", 32'(deadlock), 32'(mHung));
  endtask

  // Model update for one rising edge using the inputs present before it.
  task automatic modelEdge();
    bit lw, br;
    lw = modelLw();
    br = modelBr();
    if (count_clr) begin
      mLw = 0;
      mBr = 0;
    end else begin
      if (lw && mLw < SAT) mLw++;
      if (br && mBr < SAT) mBr++;
    end
    if (!mHung) begin
      if (lw || br) begin
        mConsec++;
        if (mConsec >= LIMIT) mHung = 1;
      end else begin
        mConsec = 0;
      end
    end
  endtask

  task automatic modelReset();
    mLw = 0;
    mBr = 0;
    mConsec = 0;
    mHung = 0;
  endtask

  // Settle the inputs, check the combinational outputs, take one edge and
  // check the registered outputs shortly after it.
  task automatic applyStimulus();
    #1;
    checkComb();
    @(posedge clk);
    modelEdge();
    #1;
    checkRegs();
  endtask

  task automatic clearInputs();
    {RsD, RtD, RsE, RtE} = '0;
    {WriteRegE, WriteRegM, WriteRegW} = '0;
    {BranchD, RegWriteE, RegWriteM, RegWriteW} = '0;
    {MemtoRegE, MemtoRegM, count_clr} = '0;
  endtask

  // Assert reset for one edge while leaving the data inputs untouched.
  task automatic doReset();
    rst = 1'b1;
    modelReset();
    #1;
    checkComb();
    checkRegs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic setLoadUse();
    MemtoRegE = 1'b1;
    RtE = 5'd2;
    RsD = 5'd2;
  endtask

  initial begin
    rst = 1'b1;
    clearInputs();
    #2;
    modelReset();
    checkRegs();
    checkComb();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Load-use stall and its zero-register exemption.
    setLoadUse();
    applyStimulus();
    checkOutput("luStall", 32'(StallF), 32'd1);
    checkOutput("luCount", 32'(lw_stall_count), 32'd1);
    RtE = 5'd0;
    RsD = 5'd0;
    applyStimulus();
    checkOutput("luZeroNoStall", 32'(FlushE), 32'd0);

    // Forward priority: memory over writeback, nothing from $0.
    clearInputs();
    RsE = 5'd5; WriteRegM = 5'd5; RegWriteM = 1'b1; WriteRegW = 5'd5; RegWriteW = 1'b1;
    applyStimulus();
    checkOutput("fwdMem", 32'(ForwardAE), 32'd2);
    RegWriteM = 1'b0;
    applyStimulus();
    checkOutput("fwdWb", 32'(ForwardAE), 32'd1);
    RsE = 5'd0;
    applyStimulus();
    checkOutput("fwdZero", 32'(ForwardAE), 32'd0);

    // Branch hazards: ALU write in execute, then load in memory, then clear.
    doReset();
    clearInputs();
    BranchD = 1'b1; RsD = 5'd3; WriteRegE = 5'd3; RegWriteE = 1'b1;
    applyStimulus();
    checkOutput("brExStall", 32'(StallD), 32'd1);
    checkOutput("brExCount", 32'(br_stall_count), 32'd1);
    RegWriteE = 1'b0; WriteRegE = 5'd0; MemtoRegM = 1'b1; WriteRegM = 5'd3;
    applyStimulus();
    checkOutput("brMemStall", 32'(StallD), 32'd1);
    MemtoRegM = 1'b0; RegWriteM = 1'b1;
    applyStimulus();
    checkOutput("brNoStall", 32'(StallD), 32'd0);
    checkOutput("brFwdAD", 32'(ForwardAD), 32'd1);
    checkOutput("brDeadlock", 32'(deadlock), 32'd0);

    // Reset mid-run while in a stall run with counts 3/1.
    doReset();
    clearInputs();
    setLoadUse();
    applyStimulus();
    applyStimulus();
    BranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd2;
    applyStimulus();
    checkOutput("midLw", 32'(lw_stall_count), 32'd3);
    checkOutput("midBr", 32'(br_stall_count), 32'd1);
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("midRstStallF", 32'(StallF), 32'd0);
    checkOutput("midRstFlushE", 32'(FlushE), 32'd0);
    checkOutput("midRstLw", 32'(lw_stall_count), 32'd0);
    checkOutput("midRstBr", 32'(br_stall_count), 32'd0);
    checkOutput("midRstDead", 32'(deadlock), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Watchdog: a run of LIMIT stalls latches, a shorter run does not.
    clearInputs();
    setLoadUse();
    repeat (LIMIT) applyStimulus();
    checkOutput("wdHung", 32'(deadlock), 32'd1);
    clearInputs();
    applyStimulus();
    checkOutput("wdSticky", 32'(deadlock), 32'd1);
    doReset();
    checkOutput("wdRstClear", 32'(deadlock), 32'd0);
    setLoadUse();
    repeat (LIMIT - 1) applyStimulus();
    clearInputs();
    applyStimulus();
    applyStimulus();
    checkOutput("wdShortRun", 32'(deadlock), 32'd0);

    // Saturation, clear priority, and simultaneous causes.
    doReset();
    clearInputs();
    setLoadUse();
    repeat (20) applyStimulus();
    checkOutput("satLw", 32'(lw_stall_count), 32'(SAT));
    count_clr = 1'b1;
    applyStimulus();
    checkOutput("clrWins", 32'(lw_stall_count), 32'd0);
    count_clr = 1'b0;
    BranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd2;
    applyStimulus();
    checkOutput("bothLw", 32'(lw_stall_count), 32'd1);
    checkOutput("bothBr", 32'(br_stall_count), 32'd1);

    // Randomised traffic over a small register range to provoke hazards.
    doReset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) doReset();
      RsD       = 5'($urandom_range(0, 3));
      RtD       = 5'($urandom_range(0, 3));
      RsE       = 5'($urandom_range(0, 3));
      RtE       = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3));
      WriteRegM = 5'($urandom_range(0, 3));
      WriteRegW = 5'($urandom_range(0, 3));
      BranchD   = 1'($urandom_range(0, 1));
      RegWriteE = 1'($urandom_range(0, 1));
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      MemtoRegE = 1'($urandom_range(0, 1));
      MemtoRegM = 1'($urandom_range(0, 1));
      count_clr = ($urandom_range(0, 15) == 0);
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Hazard detection and forwarding control for the 5-stage pipelined MIPS core. It watches decode-stage sources and the destination/control fields leaving the decode/execute, execute/memory and memory/writeback registers. It drives the stall enables for fetch/decode, the flush (`CLR`) of the decode/execute register, and all forwarding selects. It also keeps saturating stall counters and a sticky deadlock watchdog for debug.

## Interface
- `COUNT_WIDTH`, 32: width of each stall counter.
- `DEADLOCK_LIMIT`, 4: consecutive stall cycles that latch deadlock; legal range 2..255.

- `clk`  in  1  pipeline clock
- `rst`  in  1  asynchronous, active-high reset
- `RsD`, `RtD`  in  5 each  decode-stage source registers
- `BranchD`  in  1  decode stage holds a branch (compared in decode)
- `RsE`, `RtE`  in  5 each  execute-stage source registers (from decode/execute register)
- `WriteRegE`, `WriteRegM`, `WriteRegW`  in  5 each  destination register per stage
- `RegWriteE`, `RegWriteM`, `RegWriteW`  in  1 each  register-write enable per stage
- `MemtoRegE`, `MemtoRegM`  in  1 each  stage holds a load
- `count_clr`  in  1  synchronous clear of both counters
- `StallF`, `StallD`  out  1 each  hold PC and fetch/decode register
- `FlushE`  out  1  drives `CLR` of decode/execute register
- `ForwardAE`, `ForwardBE`  out  2 each  execute operand select
- `ForwardAD`, `ForwardBD`  out  1 each  decode comparator forward from memory stage
- `lw_stall_count`, `br_stall_count`  out  `COUNT_WIDTH` each  stall cycle counts
- `deadlock`  out  1  sticky watchdog flag

## Operation
- ForwardAE:
  - `FWD_MEM` (2'b10) if RsE≠0, RsE==WriteRegM and RegWriteM.
  - Else `FWD_WB` (2'b01) if RsE≠0, RsE==WriteRegW and RegWriteW.
  - Else `FWD_NONE` (2'b00).
  - Memory stage has priority. ForwardBE is identical using RtE.
- ForwardAD = RsD≠0 && RsD==WriteRegM && RegWriteM. ForwardBD uses RtD.
- lwstall = MemtoRegE && RtE≠0 && (RsD==RtE || RtD==RtE).
- branchstall = BranchD && ((RegWriteE && WriteRegE≠0 && WriteRegE∈{RsD,RtD}) || (MemtoRegM && WriteRegM≠0 && WriteRegM∈{RsD,RtD})).
- stall = lwstall | branchstall. StallF = StallD = FlushE = stall.
- While `rst` is high, StallF, StallD and FlushE are forced 0. Forward selects are unaffected.
- Counters:
  - `lw_stall_count` increments on each edge with lwstall; `br_stall_count` on each edge with branchstall.
  - Both increment when both stalls are true in the same cycle.
  - Counters saturate at all-ones.
  - `count_clr` wins over a same-cycle increment (result 0).
- Watchdog FSM, states RUN, STALL, HUNG, with run length `run_len` (8 bits):
  - RUN: on stall go to STALL with run_len=1.
  - STALL, stall true: if run_len==DEADLOCK_LIMIT-1 go to HUNG, else run_len+1.
  - STALL, stall false: go to RUN with run_len=0.
  - HUNG: absorbing until `rst`. `deadlock` = (state==HUNG).
  - Stall/forward outputs keep operating in HUNG.
  - `count_clr` does not affect the FSM.

## Timing
- Stall, flush and forward outputs are combinational: valid in the same cycle as their inputs, zero latency.
- Counters, FSM and `deadlock` are registered and update on the rising `clk` edge following the qualifying cycle.
- Reset values: counters 0, state RUN, run_len 0, `deadlock` 0.
- Reset asserted mid-stall clears all state immediately (asynchronous).
- The legal lw→dependent-branch sequence produces 2 consecutive stall cycles. The default limit leaves margin above that.

## Structure
- Package `mips_hazard_pkg`:
  - forward encodings `FWD_NONE`/`FWD_WB`/`FWD_MEM`
  - watchdog state enum `RUN`/`STALL`/`HUNG`
  - `REG_ZERO` = 5'd0
- Sub-module `hazard_perf_counter`: parameterised saturating counter with `inc`/`clr`, clr priority. It is instantiated twice.
- The top level holds the comparators, the FSM and the output gating.

## Test plan
- Reset mid-run: assert `rst` while in STALL with counts 3/1 → counters 0, `deadlock` 0, StallF/StallD/FlushE 0 while `rst` high.
- Load-use: MemtoRegE=1, RtE=2, RsD=2 → StallF=StallD=FlushE=1 in the same cycle, `lw_stall_count` 0→1 next edge. Same with RtE=0, RsD=0 → no stall.
- Forward priority: RsE=5, WriteRegM=5/RegWriteM=1, WriteRegW=5/RegWriteW=1 → ForwardAE=2'b10. With RegWriteM=0 → 2'b01. With RsE=0 → 2'b00.
- Branch hazards:
  - BranchD=1, RsD=3, WriteRegE=3, RegWriteE=1 → stall; `br_stall_count` +1.
  - Next cycle: MemtoRegM=1, WriteRegM=3 → stall again.
  - Then RegWriteM=1 with MemtoRegM=0 → no stall, ForwardAD=1.
- Watchdog: hold lwstall for 4 cycles (limit 4) → `deadlock`=1 after the 4th edge. It stays 1 after the stall drops and clears only on `rst`. Holding 3 cycles then releasing → `deadlock` stays 0.
- Saturation/clear with COUNT_WIDTH=4:
  - 20 lwstall cycles → `lw_stall_count`=15.
  - `count_clr`=1 with lwstall=1 in the same cycle → 0.
  - Simultaneous lw and branch stall → both counters +1.
